// File: rtl/audio_pwm_dac.sv
`timescale 1ns/1ps
// audio_pwm_dac: turns 8-bit unsigned audio samples into a 1-bit PWM stream.
// It holds one pending sample, attenuates by a power of two at load time, and
// paces the upstream driver with sample_req. A period boundary that finds no
// pending sample repeats the previous level and is logged as an underrun.
module audio_pwm_dac #(
    parameter int PRESCALE = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic [7:0] sample_in,
    input  logic       sample_valid,
    input  logic [2:0] vol,
    output logic       sample_req,
    output logic       pwm_out,
    output logic       underrun,
    output logic [7:0] underrun_count
);

    localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);

    logic [PRE_W-1:0]  pre;
    logic [7:0]        cnt;
    logic [7:0]        pending;
    logic              pend_v;
    logic [7:0]        active;
    logic              tick;
    logic              boundary;
    logic signed [8:0] diff;
    logic signed [8:0] shifted;
    logic [7:0]        scaled;

    // A slot ends on the last prescaler cycle; the period ends on the last slot.
    assign tick       = enable && (pre == PRE_LAST);
    assign boundary   = tick && (cnt == 8'hFF);

    // Mid-period request leaves the driver half a period to respond.
    assign sample_req = tick && (cnt == 8'd127);

    // Attenuate around midscale so silence stays at 0x80 for every volume.
    always_comb begin
        diff    = $signed({1'b0, pending}) - 9'sd128;
        shifted = diff >>> vol;
        scaled  = 8'(shifted + 9'sd128);
    end

    // Prescaler and slot counter; both restart from zero whenever stopped.
    always_ff @(posedge clk) begin
        if (rst) begin
            pre <= '0;
            cnt <= '0;
        end else if (!enable) begin
            pre <= '0;
            cnt <= '0;
        end else begin
            if (tick) begin
                pre <= '0;
                cnt <= cnt + 8'd1;
            end else begin
                pre <= pre + 1'b1;
            end
        end
    end

    // One-deep sample buffer; the boundary consumes the old sample before a
    // same-cycle write refills it.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending <= 8'h00;
            pend_v  <= 1'b0;
            active  <= 8'h80;
        end else begin
            if (boundary && pend_v) begin
                active <= scaled;
            end
            if (sample_valid) begin
                pending <= sample_in;
                pend_v  <= 1'b1;
            end else if (boundary && pend_v) begin
                pend_v <= 1'b0;
            end
        end
    end

    // Sticky underrun flag and saturating count, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            underrun       <= 1'b0;
            underrun_count <= 8'h00;
        end else if (boundary && !pend_v) begin
            underrun <= 1'b1;
            if (underrun_count != 8'hFF) begin
                underrun_count <= underrun_count + 8'd1;
            end
        end
    end

    // Registered duty compare, forced low while stopped.
    always_ff @(posedge clk) begin
        if (rst) begin
            pwm_out <= 1'b0;
        end else begin
            pwm_out <= enable && (cnt < active);
        end
    end

endmodule

// File: tb/tb_audio_pwm_dac.sv
`timescale 1ns/1ps
// tb_audio_pwm_dac: directed bench with a sample scoreboard. Samples handed to
// the DUT are queued as pending, converted to expected PWM levels at each
// period boundary, and compared against measured duty per period.
module tb_audio_pwm_dac;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Main instance, PRESCALE = 1
    logic       rst_a, enable_a, valid_a, req_a, pwm_a, und_a;
    logic [7:0] sample_a, ucnt_a;
    logic [2:0] vol_a;

    // Prescaled instance, PRESCALE = 4
    logic       rst_b, enable_b, valid_b, req_b, pwm_b, und_b;
    logic [7:0] sample_b, ucnt_b;
    logic [2:0] vol_b;

    // Free-running starved instance for counter saturation
    logic       rst_s, enable_s, valid_s, req_s, pwm_s, und_s;
    logic [7:0] sample_s, ucnt_s;
    logic [2:0] vol_s;

    audio_pwm_dac #(.PRESCALE(1)) u_a (
        .clk(clk), .rst(rst_a), .enable(enable_a), .sample_in(sample_a),
        .sample_valid(valid_a), .vol(vol_a), .sample_req(req_a),
        .pwm_out(pwm_a), .underrun(und_a), .underrun_count(ucnt_a)
    );

    audio_pwm_dac #(.PRESCALE(4)) u_b (
        .clk(clk), .rst(rst_b), .enable(enable_b), .sample_in(sample_b),
        .sample_valid(valid_b), .vol(vol_b), .sample_req(req_b),
        .pwm_out(pwm_b), .underrun(und_b), .underrun_count(ucnt_b)
    );

    audio_pwm_dac #(.PRESCALE(1)) u_s (
        .clk(clk), .rst(rst_s), .enable(enable_s), .sample_in(sample_s),
        .sample_valid(valid_s), .vol(vol_s), .sample_req(req_s),
        .pwm_out(pwm_s), .underrun(und_s), .underrun_count(ucnt_s)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int sat_start;

    int feed_q[$];
    int feedvol_q[$];
    int pend_q[$];
    int play_q[$];
    int last_level;
    int exp_und;
    int exp_ucnt;

    // Advance one clock and settle just past the edge.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Attenuation as a floor division of the signed midscale offset.
    function automatic int scale_model(input int sample, input int shift);
        int d;
        int p;
        d = sample - 128;
        p = 1 << shift;
        if (d >= 0) return 128 + d / p;
        return 128 - ((-d + p - 1) / p);
    endfunction

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        n_checks++;
        assert (observed === expected) begin
            n_pass++;
        end else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    // Reset the main instance and restart its scoreboard.
    task automatic reset_a();
        rst_a   = 1'b1;
        valid_a = 1'b0;
        vol_a   = 3'd0;
        step();
        step();
        rst_a = 1'b0;
        feed_q.delete();
        feedvol_q.delete();
        pend_q.delete();
        play_q.delete();
        play_q.push_back(128);
        last_level = 128;
        exp_und    = 0;
        exp_ucnt   = 0;
    endtask

    // Run one 256-cycle period of the main instance, answering sample_req from
    // the feed queue; optionally drive an extra sample into the boundary cycle.
    task automatic apply_stimulus(input string tag, input logic extra_v,
                                  input int extra_s);
        int highs;
        int reqs;
        int expected;
        highs = 0;
        reqs  = 0;
        for (int i = 0; i < 256; i++) begin
            step();
            highs += int'(pwm_a);
            valid_a = 1'b0;
            if (req_a) begin
                reqs++;
                if (feed_q.size() > 0) begin
                    sample_a = 8'(feed_q.pop_front());
                    vol_a    = 3'(feedvol_q.pop_front());
                    valid_a  = 1'b1;
                    pend_q.delete();
                    pend_q.push_back(int'(sample_a));
                end
            end
            if (extra_v && i == 254) begin
                sample_a = 8'(extra_s);
                valid_a  = 1'b1;
            end
        end
        expected = play_q.pop_front();
        check_output({tag, " duty"}, highs, expected);
        check_output({tag, " req_per_period"}, reqs, 1);
        if (pend_q.size() > 0) begin
            last_level = scale_model(pend_q.pop_front(), int'(vol_a));
        end else begin
            exp_und = 1;
            if (exp_ucnt < 255) exp_ucnt++;
        end
        play_q.push_back(last_level);
        if (extra_v) begin
            pend_q.delete();
            pend_q.push_back(extra_s);
        end
        check_output({tag, " underrun"}, und_a, exp_und);
        check_output({tag, " underrun_count"}, ucnt_a, exp_ucnt);
    endtask

    initial begin
        int first_req;
        int second_req;
        int first_low;
        int highs;
        int reqs;

        rst_a = 1'b1; enable_a = 1'b1; valid_a = 1'b0; sample_a = 8'h00; vol_a = 3'd0;
        rst_b = 1'b1; enable_b = 1'b0; valid_b = 1'b0; sample_b = 8'h00; vol_b = 3'd0;
        rst_s = 1'b1; enable_s = 1'b1; valid_s = 1'b0; sample_s = 8'h00; vol_s = 3'd0;

        step();
        step();
        $display("[TB] reset values");
        check_output("reset pwm_out", pwm_a, 1'b0);
        check_output("reset sample_req", req_a, 1'b0);
        check_output("reset underrun", und_a, 1'b0);
        check_output("reset underrun_count", ucnt_a, 8'h00);

        rst_s = 1'b0;
        sat_start = cyc;

        $display("[TB] starved playback repeats midscale");
        reset_a();
        apply_stimulus("starve p0", 1'b0, 0);
        apply_stimulus("starve p1", 1'b0, 0);

        $display("[TB] fed playback with attenuation");
        reset_a();
        feed_q = '{8'h40, 8'h40, 8'h00, 8'hFF, 8'h00, 8'hFF, 8'h00, 8'hFF};
        feedvol_q = '{0, 0, 1, 1, 7, 7, 0, 0};
        for (int p = 0; p < 9; p++) begin
            apply_stimulus($sformatf("feed p%0d", p), 1'b0, 0);
        end

        $display("[TB] sample arriving on the boundary cycle");
        reset_a();
        feed_q.push_back(8'h20);
        feedvol_q.push_back(0);
        apply_stimulus("collide p0", 1'b1, 8'hE0);
        apply_stimulus("collide p1", 1'b0, 0);
        apply_stimulus("collide p2", 1'b0, 0);

        $display("[TB] reset mid-period");
        for (int i = 0; i < 20; i++) step();
        check_output("midrst pre pwm_out", pwm_a, 1'b1);
        check_output("midrst pre underrun", und_a, 1'b1);
        rst_a = 1'b1;
        step();
        check_output("midrst pwm_out", pwm_a, 1'b0);
        check_output("midrst sample_req", req_a, 1'b0);
        check_output("midrst underrun", und_a, 1'b0);
        check_output("midrst underrun_count", ucnt_a, 8'h00);
        reset_a();
        apply_stimulus("after rst p0", 1'b0, 0);

        $display("[TB] prescale 4 timing");
        enable_b = 1'b1;
        rst_b    = 1'b1;
        step();
        rst_b = 1'b0;
        first_req  = -1;
        second_req = -1;
        first_low  = -1;
        highs      = 0;
        for (int i = 1; i <= 2100; i++) begin
            step();
            if (i <= 1024) highs += int'(pwm_b);
            if (req_b) begin
                if (first_req < 0) first_req = i;
                else if (second_req < 0) second_req = i;
            end
            if (!pwm_b && first_low < 0) first_low = i;
        end
        check_output("p4 first req", first_req, 511);
        check_output("p4 req spacing", second_req - first_req, 1024);
        check_output("p4 duty", highs, 512);
        check_output("p4 first low", first_low, 513);
        check_output("p4 underrun", und_b, 1'b1);
        check_output("p4 underrun_count", ucnt_b, 8'd2);

        $display("[TB] prescale 4 stop and restart");
        check_output("p4 pre stop pwm_out", pwm_b, 1'b1);
        enable_b = 1'b0;
        step();
        check_output("p4 stop pwm_out", pwm_b, 1'b0);
        highs = 0;
        reqs  = 0;
        for (int i = 0; i < 300; i++) begin
            step();
            highs += int'(pwm_b);
            reqs  += int'(req_b);
        end
        check_output("p4 stopped highs", highs, 0);
        check_output("p4 stopped reqs", reqs, 0);
        check_output("p4 stopped underrun_count", ucnt_b, 8'd2);
        enable_b  = 1'b1;
        first_req = -1;
        for (int i = 1; i <= 600; i++) begin
            step();
            if (req_b && first_req < 0) first_req = i;
        end
        check_output("p4 restart first req", first_req, 511);

        $display("[TB] underrun count saturation");
        while ((cyc - sat_start) < 256 * 254) step();
        check_output("sat count 254", ucnt_s, 8'd254);
        check_output("sat underrun", und_s, 1'b1);
        for (int i = 0; i < 256; i++) step();
        check_output("sat count 255", ucnt_s, 8'd255);
        for (int i = 0; i < 256; i++) step();
        check_output("sat count held", ucnt_s, 8'd255);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/audio_pwm_dac.md
# audio_pwm_dac

Downstream output stage for the audio ROM playback path. It takes the 8-bit unsigned samples produced by the ROM-driven audio driver and converts them to a 1-bit PWM stream for an external RC filter or amplifier pin. Its `sample_req` output is the pacing strobe for the driver's `ena` input. It applies a power-of-two attenuation, buffers one pending sample, and reports underruns.

## Interface
- `PRESCALE`, default 1: PWM slot length in clk cycles (≥1); PWM period = 256·PRESCALE cycles.
- `clk` input 1: single clock; all state on rising edge.
- `rst` input 1: synchronous, active-high reset.
- `enable` input 1: run/stop for the PWM engine.
- `sample_in` input 8: unsigned sample, midscale 0x80 = silence.
- `sample_valid` input 1: `sample_in` valid this cycle; captured unconditionally.
- `vol` input 3: attenuation shift, 0 = full scale, 7 = max attenuation.
- `sample_req` output 1: one-cycle pulse requesting the next sample (drive upstream `ena`).
- `pwm_out` output 1: registered PWM output.
- `underrun` output 1: sticky; set when a period starts with no pending sample.
- `underrun_count` output 8: saturating count of underrun periods.

## Operation
- Prescaler `pre` counts 0..PRESCALE-1. `tick` = enable && pre==PRESCALE-1; with PRESCALE=1, tick = enable every cycle.
- Slot counter `cnt` (8 bit) increments on tick and wraps 255→0.
- Period boundary = tick with cnt==255.
- Pending buffer: `sample_valid` writes `pending <= sample_in` and `pend_v <= 1`. A write while `pend_v` is already 1 overwrites; newest wins, with no flag.
- At a period boundary with `pend_v`=1: `active <= scale(pending, vol)` and `pend_v <= 0`.
- At a period boundary with `pend_v`=0: `active` holds (repeat last sample), `underrun <= 1`, and `underrun_count` increments, saturating at 255.
- Boundary and `sample_valid` in the same cycle: `active` loads the old pending, `pending` takes the new sample, and `pend_v` stays 1.
- Scaling: d = {1'b0,pending} − 128 as signed 9-bit; s = d >>> vol (arithmetic shift); result = 128 + s, which always fits in 8 bits. `vol` is sampled only at the load cycle.
- `sample_req` pulses high for one cycle on the tick where cnt==127. This gives the upstream stage half a period to deliver.
- `pwm_out <= enable && (cnt < active)`. Duty = active/256: active=0 gives constant low, active=255 gives high for 255 of 256 slots.
- `enable`=0: `pre` and `cnt` are cleared to 0, no `sample_req` is issued, no boundaries occur, and `pwm_out` is 0. `pending`, `pend_v`, `active`, and the underrun state are retained.
- `underrun` and `underrun_count` are cleared only by `rst`.

## Timing
- Reset values: `pwm_out`=0, `sample_req`=0, `underrun`=0, `underrun_count`=0, `pre`=0, `cnt`=0, `active`=0x80, `pend_v`=0, `pending`=0x00.
- `rst` mid-period aborts immediately. After the reset cycle, the first tick occurs after PRESCALE enabled cycles.
- `pwm_out` lags `cnt` by one cycle (registered compare).
- New `active` takes effect on the first slot (cnt=0) of the next period. Its first `pwm_out` reflects it one cycle after the boundary.
- Upstream handshake: the driver registers its output one cycle after `ena`, so `sample_valid` = `sample_req` delayed by one cycle. This arrives well before the boundary at cnt==255.
- A sample delivered before the first boundary after reset plays in period 1. If none is delivered, period 1 repeats 0x80 and flags underrun.
- `sample_req` period is exactly 256·PRESCALE cycles while enabled.

## Test plan
- Reset, enable=1, PRESCALE=1, no `sample_valid` -> `pwm_out` high for 128 of every 256 cycles. `underrun`=1 after the first boundary; `underrun_count` increments once per period and saturates at 255.
- Feed 0x40 with vol=0 on each `sample_req`+1 -> `pwm_out` high for 64 of every 256 cycles. `underrun` stays 0 from the second period on.
- vol=1 with samples 0x00 and 0xFF -> active 0x40 and 0xBF. vol=7 with the same samples -> 0x7F and 0x80.
- `sample_valid` asserted in the same cycle as a boundary with pending 0x20 and new 0xE0 -> current period uses 0x20, next period uses 0xE0, no underrun.
- PRESCALE=4: `sample_req` spacing is 1024 cycles and each PWM slot lasts 4 cycles. Dropping `enable` mid-period forces `pwm_out`=0 next cycle. On re-enable, the period restarts from cnt=0.
- Sample 0x00 gives `pwm_out` constant 0. Sample 0xFF gives exactly one low cycle per period. `rst` asserted mid-period returns all outputs to their reset values on the next edge.
